dmem_responder: RTL and testbench

- Multi-cycle data-memory responder. It is the slave end of the pipeline's MEM-stage load/store interface.
- Accepts one load or store per transaction: address, write data and funct3 size/sign code.
- Holds the pipeline with `busy` for a programmable latency, then returns aligned, sign/zero-extended read data or an error flag.
- Replaces the single-cycle data memory, so cache-like latency can be modelled behind the existing MEM stage.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_lane_align.sv | 79 +++++++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_pkg;

    // The request struct is sized from these. The top's DM_ADDRESS / DATA_W
    // parameters must match them.
    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 32;

    // RISC-V load/store size/sign codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic                   write;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [2:0]             funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads/stores: byte enables, store merge, load extension, error detect.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
//
// Ports:
//   funct3_i    size/sign code
//   lane_i      addr[1:0]
//   write_i     1 = store
//   rdata_raw_i word currently held in storage
//   wdata_i     store data, low bytes significant for SB/SH
//   be_o        byte enables (all zero on error)
//   wmerge_o    raw word with the enabled lanes replaced by store data
//   rdata_o     extended load data (zero for stores and errors)
//   err_o       misaligned access or illegal funct3
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic        write_i,
    input  logic [31:0] rdata_raw_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wmerge_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [31:0] rd_shift;   // selected lane moved down to bit 0
    logic [31:0] wd_shift;   // store data moved up to its lane
    logic [3:0]  be_raw;
    logic        err;

    always_comb begin
        rd_shift = rdata_raw_i >> {lane_i, 3'b000};
        wd_shift = wdata_i << {lane_i, 3'b000};
        be_raw   = 4'b0000;
        err      = 1'b0;

        case (funct3_i)
            F3_B, F3_BU: be_raw = 4'b0001 << lane_i;
            F3_H, F3_HU: begin
                be_raw = 4'b0011 << lane_i;
                err    = lane_i[0];
            end
            F3_W: begin
                be_raw = 4'b1111;
                err    = (lane_i != 2'b00);
            end
            default: err = 1'b1;
        endcase

        // Unsigned variants exist only for loads.
        if (write_i && funct3_i[2]) begin
            err = 1'b1;
        end

        case (funct3_i)
            F3_B:    rdata_o = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_BU:   rdata_o = {24'h0, rd_shift[7:0]};
            F3_H:    rdata_o = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_HU:   rdata_o = {16'h0, rd_shift[15:0]};
            F3_W:    rdata_o = rd_shift;   // lane is 0 whenever this is legal
            default: rdata_o = 32'h0;
        endcase

        if (err || write_i) begin
            rdata_o = 32'h0;
        end

        be_o  = err ? 4'b0000 : be_raw;
        err_o = err;

        for (int i = 0; i < 4; i++) begin
            wmerge_o[8*i +: 8] = be_o[i] ? wd_shift[8*i +: 8] : rdata_raw_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave behind the MEM stage: one load/store per transaction.
// Latency: response pulse LATENCY cycles after the request is presented (1..15).
// Backpressure: busy stalls the pipeline while the request is accepted and in WAIT; low in RESP.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req_valid          request present, held by the pipeline while busy
//   req_write          1 = store, 0 = load
//   req_addr           byte address
//   req_wdata          store data
//   req_funct3         size/sign code
//   busy               stall to pipeline
//   rsp_valid          one-cycle completion pulse
//   rsp_rdata          extended load data, 0 for stores/errors
//   rsp_err            misaligned access or illegal funct3
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int DM_ADDRESS = DMEM_ADDR_W,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int WORDS = 1 << (DM_ADDRESS - 2);

    dmem_state_t         state_q;
    logic [3:0]          cnt_q;
    dmem_req_t           req_q;
    dmem_req_t           cur_req;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   mem_q [WORDS];

    logic [DM_ADDRESS-3:0] widx;
    logic [DATA_W-1:0]     raw_word;
    logic [3:0]            be;
    logic [DATA_W-1:0]     wmerge;
    logic [DATA_W-1:0]     ld_data;
    logic                  acc_err;
    logic                  finish;

    // With LATENCY=1 the transaction completes on the accept edge, before
    // req_q is loaded, so the live request feeds the datapath while IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            cur_req.write  = req_write;
            cur_req.addr   = req_addr;
            cur_req.wdata  = req_wdata;
            cur_req.funct3 = req_funct3;
        end else begin
            cur_req = req_q;
        end
    end

    assign widx     = cur_req.addr[DM_ADDRESS-1:2];
    assign raw_word = mem_q[widx];

    // The edge on which the FSM enters RESP: memory access happens here.
    assign finish = ((state_q == IDLE) && req_valid && (LATENCY == 1))
                 || ((state_q == WAIT) && (cnt_q == 4'd0));

    assign busy = ((state_q == IDLE) && req_valid) || (state_q == WAIT);

    dmem_lane_align u_align (
        .funct3_i    (cur_req.funct3),
        .lane_i      (cur_req.addr[1:0]),
        .write_i     (cur_req.write),
        .rdata_raw_i (raw_word),
        .wdata_i     (cur_req.wdata),
        .be_o        (be),
        .wmerge_o    (wmerge),
        .rdata_o     (ld_data),
        .err_o       (acc_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_q <= cur_req;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                // The request still visible here is the one completing now.
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (finish) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= ld_data;
                rsp_err_q   <= acc_err;
            end
        end
    end

    // Storage is not reset; a reset during WAIT drops the pending store.
    always_ff @(posedge clk) begin
        if (!reset && finish && cur_req.write && (be != 4'b0000)) begin
            mem_q[widx] <= wmerge;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) driven with directed and random loads/stores.
// Expected responses come from a byte-array reference model and are queued at issue time.
// A negedge monitor pops and compares whenever rsp_valid is seen.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int AW   = 9;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst  [2];
    logic          vld  [2];
    logic          wr   [2];
    logic [AW-1:0] addr [2];
    logic [31:0]   wdat [2];
    logic [2:0]    f3   [2];
    logic          busy [2];
    logic          rv   [2];
    logic [31:0]   rdat [2];
    logic          rerr [2];

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(AW), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(vld[0]), .req_write(wr[0]),
        .req_addr(addr[0]), .req_wdata(wdat[0]), .req_funct3(f3[0]),
        .busy(busy[0]), .rsp_valid(rv[0]), .rsp_rdata(rdat[0]), .rsp_err(rerr[0])
    );

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(AW), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(vld[1]), .req_write(wr[1]),
        .req_addr(addr[1]), .req_wdata(wdat[1]), .req_funct3(f3[1]),
        .busy(busy[1]), .rsp_valid(rv[1]), .rsp_rdata(rdat[1]), .rsp_err(rerr[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          issue_cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  mdl [2][512];   // byte-addressed reference memory per DUT
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference: size in bytes from funct3, natural alignment, little-endian bytes.
    function automatic void model(int d, logic w, logic [AW-1:0] a, logic [31:0] wd,
                                  logic [2:0] f, output logic [31:0] rd, output logic e);
        int nbytes;
        int base;
        logic [31:0] v;
        base = int'(a);
        case (f[1:0])
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 4;
            default: nbytes = 0;
        endcase
        rd = 32'h0;
        e  = (nbytes == 0) || (f == 3'd6) || (w && (f == 3'd4 || f == 3'd5))
          || (base % nbytes != 0);
        if (e) return;
        if (w) begin
            for (int b = 0; b < nbytes; b++) mdl[d][base + b] = wd[8*b +: 8];
        end else begin
            v = 32'h0;
            for (int b = 0; b < nbytes; b++) v[8*b +: 8] = mdl[d][base + b];
            if (f[2] == 1'b0 && v[8*nbytes - 1] == 1'b1)
                for (int b = nbytes; b < 4; b++) v[8*b +: 8] = 8'hFF;
            rd = v;
        end
    endfunction

    // Present one request, hold it while busy (scrambling the fields once it is
    // accepted), return during the RESP cycle.
    task automatic issue(int d, logic w, logic [AW-1:0] a, logic [31:0] wd, logic [2:0] f);
        exp_t e;
        int   nb;
        int   lat;
        lat = (d == 0) ? LAT0 : LAT1;
        @(negedge clk);
        vld[d] = 1'b1; wr[d] = w; addr[d] = a; wdat[d] = wd; f3[d] = f;
        model(d, w, a, wd, f, e.rdata, e.err);
        e.issue_cyc = cyc;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        #1;
        nb = 0;
        while (busy[d] && nb < 40) begin
            nb++;
            @(negedge clk);
            if (busy[d]) begin
                wr[d]   = 1'($urandom);
                addr[d] = AW'($urandom);
                wdat[d] = $urandom;
                f3[d]   = 3'($urandom);
            end
            #1;
        end
        check($sformatf("busy_cycles[%0d]", d), 32'(nb), 32'(lat));
    endtask

    task automatic idle(int d);
        @(negedge clk);
        vld[d] = 1'b0;
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rv[d] === 1'b1) begin
                exp_t e;
                int   lat;
                bit   have;
                lat  = (d == 0) ? LAT0 : LAT1;
                have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (!have) begin
                    n_chk++;
                    $display("FAIL unexpected_rsp[%0d]: rsp_valid=1, expected none", d);
                end else begin
                    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                    check($sformatf("rdata[%0d]@%0d", d, cyc), rdat[d], e.rdata);
                    check($sformatf("err[%0d]@%0d", d, cyc), 32'(rerr[d]), 32'(e.err));
                    check($sformatf("latency[%0d]", d), 32'(cyc - e.issue_cyc), 32'(lat));
                    check($sformatf("busy_in_resp[%0d]", d), 32'(busy[d]), 32'd0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; vld[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; wdat[d] = '0; f3[d] = '0;
            for (int i = 0; i < 512; i++) mdl[d][i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_busy[%0d]", d), 32'(busy[d]), 32'd0);
            check($sformatf("rst_valid[%0d]", d), 32'(rv[d]), 32'd0);
            check($sformatf("rst_rdata[%0d]", d), rdat[d], 32'd0);
            check($sformatf("rst_err[%0d]", d), 32'(rerr[d]), 32'd0);
            rst[d] = 1'b0;
        end

        // Give the words used below a defined value.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) issue(d, 1'b1, AW'(4 * i), 32'h0, F3_W);
            idle(d);
        end

        // Directed sequence on the LATENCY=2 instance
        issue(0, 1'b1, 9'h010, 32'hDEADBEEF, F3_W);
        issue(0, 1'b0, 9'h010, 32'h0, F3_W);
        issue(0, 1'b0, 9'h013, 32'h0, F3_B);
        issue(0, 1'b0, 9'h013, 32'h0, F3_BU);
        issue(0, 1'b0, 9'h010, 32'h0, F3_H);
        issue(0, 1'b0, 9'h012, 32'h0, F3_HU);
        issue(0, 1'b1, 9'h011, 32'h000000AA, F3_B);
        issue(0, 1'b0, 9'h010, 32'h0, F3_W);
        issue(0, 1'b0, 9'h012, 32'h0, F3_W);
        issue(0, 1'b1, 9'h011, 32'h0000CAFE, F3_H);
        issue(0, 1'b1, 9'h010, 32'h11111111, 3'b100);
        issue(0, 1'b0, 9'h010, 32'h0, 3'b011);
        issue(0, 1'b0, 9'h010, 32'h0, F3_W);
        idle(0);

        // Back-to-back loads on the LATENCY=1 instance
        issue(1, 1'b1, 9'h004, 32'hA5A5_5A5A, F3_W);
        issue(1, 1'b0, 9'h000, 32'h0, F3_W);
        issue(1, 1'b0, 9'h004, 32'h0, F3_W);
        idle(1);

        // Randomized traffic over a 64-byte window so reads hit recent writes
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                issue(d, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                      $urandom, 3'($urandom_range(0, 7)));
                if ($urandom_range(0, 3) == 0) idle(d);
            end
            idle(d);
        end

        // Reset during WAIT discards the pending store and produces no response.
        @(negedge clk);
        vld[0] = 1'b1; wr[0] = 1'b1; addr[0] = 9'h020; wdat[0] = 32'h12345678; f3[0] = F3_W;
        @(negedge clk);
        check("busy_in_wait", 32'(busy[0]), 32'd1);
        rst[0] = 1'b1; vld[0] = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(rv[0]), 32'd0);
        check("post_rst_rdata", rdat[0], 32'd0);
        check("post_rst_err", 32'(rerr[0]), 32'd0);
        check("post_rst_busy", 32'(busy[0]), 32'd0);
        rst[0] = 1'b0;
        repeat (3) @(negedge clk);
        issue(0, 1'b0, 9'h020, 32'h0, F3_W);
        idle(0);

        repeat (5) @(negedge clk);
        check("pending_rsp[0]", 32'(q0.size()), 32'd0);
        check("pending_rsp[1]", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
